// File: rtl/img_sensor_emu.sv
// Image-sensor transmitter emulator.
// Produces a synthetic 4-lane, 12-bit frame on a bit-interleaved 32-bit bus:
// per line an xhs pulse, training bytes, a SAV code, packed pixel pairs and a
// tail. It stands in for the LVDS deserializer so the capture path can be
// exercised without a sensor attached.
module img_sensor_emu #(
  parameter int         CH_PIX     = 512,   // pixels per lane per line, even
  parameter int         LINES      = 2048,  // lines per frame
  parameter int         XHS_W      = 8,     // xhs low width in cycles
  parameter int         TRAIN_LEN  = 16,    // training cycles after xhs
  parameter int         TAIL_LEN   = 32,    // idle cycles after pixels
  parameter logic [7:0] TRAIN_BYTE = 8'hA5  // idle / training byte
) (
  input  logic        dck,
  input  logic        rst,
  input  logic        frame_trig,
  input  logic [1:0]  mode,
  input  logic [11:0] const_pix,
  output logic [31:0] data_par,
  output logic        xhs,
  output logic        busy,
  output logic        line_active,
  output logic [10:0] line_num,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XHS,
    S_TRAIN,
    S_SAV,
    S_PIX,
    S_TAIL
  } state_t;

  // Last count value of each timed state (counters run 0 .. LEN-1).
  localparam logic [15:0] XHS_LAST   = 16'(XHS_W - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);
  localparam logic [15:0] SAV_LAST   = 16'd5;
  localparam logic [15:0] PIX_LAST   = 16'(3 * CH_PIX / 2 - 1);
  localparam logic [15:0] TAIL_LAST  = 16'(TAIL_LEN - 1);
  localparam logic [10:0] LINE_LAST  = 11'(LINES - 1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;          // cycle count inside the current state
  logic [1:0]        phase_q, phase_d;      // 3-phase gearbox position
  logic [10:0]       pair_q, pair_d;        // pixel-pair index within the line
  logic [10:0]       line_q, line_d;
  logic [1:0]        mode_q, mode_d;        // pattern latched at frame start
  logic [11:0]       cpix_q, cpix_d;        // constant pixel latched at frame start
  logic [3:0][7:0]   lanes_q, lanes_d;      // one output byte per channel
  logic              xhs_q, xhs_d;
  logic              busy_q, busy_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [11:0]       pix0, pix1;

  // Test pattern value for lane, in-lane column x and line y.
  function automatic logic [11:0] pix_val(input logic [1:0]  lane,
                                          input logic [11:0] x,
                                          input logic [10:0] y,
                                          input logic [1:0]  md,
                                          input logic [11:0] cp);
    logic [11:0] base;
    logic [11:0] v;
    base = 12'(int'(lane) * CH_PIX);
    unique case (md)
      2'd0:    v = base + x;                    // horizontal ramp, wraps at 4096
      2'd1:    v = {1'b0, y};                   // line number
      2'd2:    v = (x[4] ^ y[4]) ? 12'hFFF : 12'h000;  // 16x16 checkerboard
      default: v = cp;
    endcase
    return v;
  endfunction

  // SAV code FFF,000,000,800 packed two pixels per three bytes.
  function automatic logic [7:0] sav_byte(input logic [2:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = 8'hFF;
      3'd1:    b = 8'hF0;
      3'd4:    b = 8'h08;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state, counter and control-output logic.
  // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pair_d  = pair_q;
    line_d  = line_q;
    mode_d  = mode_q;
    cpix_d  = cpix_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A trigger on the frame_done cycle is dropped; it must come again.
        if (frame_trig && !done_q) begin
          state_d = S_XHS;
          cnt_d   = '0;
          line_d  = '0;
          mode_d  = mode;
          cpix_d  = const_pix;
        end
      end
      S_XHS: begin
        if (cnt_q == XHS_LAST) begin
          state_d = S_TRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_TRAIN: begin
        if (cnt_q == TRAIN_LAST) begin
          state_d = S_SAV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SAV: begin
        if (cnt_q == SAV_LAST) begin
          state_d = S_PIX;
          cnt_d   = '0;
          phase_d = 2'd0;
          pair_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PIX: begin
        if (cnt_q == PIX_LAST) begin
          state_d = S_TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            pair_d  = pair_q + 11'd1;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          cnt_d = '0;
          if (line_q < LINE_LAST) begin
            state_d = S_XHS;
            line_d  = line_q + 11'd1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    xhs_d    = (state_d != S_XHS);
    busy_d   = (state_d != S_IDLE);
    active_d = (state_d == S_PIX);
  end

  // Per-lane byte selection: training byte, SAV code or gearbox-packed pixels.
  always_comb begin
    pix0 = '0;
    pix1 = '0;
    for (int k = 0; k < 4; k++) begin
      pix0       = pix_val(2'(k), {pair_d, 1'b0}, line_d, mode_d, cpix_d);
      pix1       = pix_val(2'(k), {pair_d, 1'b1}, line_d, mode_d, cpix_d);
      lanes_d[k] = TRAIN_BYTE;
      if (state_d == S_SAV) begin
        lanes_d[k] = sav_byte(cnt_d[2:0]);
      end else if (state_d == S_PIX) begin
        unique case (phase_d)
          2'd0:    lanes_d[k] = pix0[11:4];
          2'd1:    lanes_d[k] = {pix0[3:0], pix1[11:8]};
          default: lanes_d[k] = pix1[7:0];
        endcase
      end
    end
  end

  // State, counters and registered outputs; synchronous reset abandons any frame.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge dck) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= '0;
      pair_q   <= '0;
      line_q   <= '0;
      mode_q   <= '0;
      cpix_q   <= '0;
      lanes_q  <= {4{TRAIN_BYTE}};
      xhs_q    <= 1'b1;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      pair_q   <= pair_d;
      line_q   <= line_d;
      mode_q   <= mode_d;
      cpix_q   <= cpix_d;
      lanes_q  <= lanes_d;
      xhs_q    <= xhs_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Bit-interleave the lane bytes: bit i of lane k lands on data_par[4*i+k].
  always_comb begin
    data_par = '0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        data_par[4*i+k] = lanes_q[k][i];
      end
    end
  end

  assign xhs         = xhs_q;
  assign busy        = busy_q;
  assign line_active = active_q;
  assign line_num    = line_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_img_sensor_emu.sv
// Bench for img_sensor_emu: a frame-level reference model fills a per-instance
// expectation queue whenever a frame is triggered; monitors pop and compare
// every cycle the DUT presents output (busy or frame_done).
module tb_img_sensor_emu;

  localparam int XW    = 8;
  localparam int TL    = 16;
  localparam int TAILL = 32;
  localparam int DF_CH = 512;
  localparam int DF_LN = 2048;
  localparam int SM_CH = 32;
  localparam int SM_LN = 32;
  localparam int SM_FRAME = SM_LN * (XW + TL + 6 + 3 * SM_CH / 2 + TAILL) + 1;

  typedef struct packed {
    logic [31:0] lanes;   // {lane3, lane2, lane1, lane0}
    logic        xhs;
    logic        busy;
    logic        act;
    logic        done;
    logic [10:0] ln;
  } rec_t;

  logic dck = 1'b0;
  always #5 dck = ~dck;

  // Default-parameter instance
  logic        df_rst = 1'b1, df_trig = 1'b0;
  logic [1:0]  df_mode = '0;
  logic [11:0] df_cp = '0;
  logic [31:0] df_data;
  logic        df_xhs, df_busy, df_act, df_done;
  logic [10:0] df_ln;

  // Small instance for whole-frame checks
  logic        sm_rst = 1'b1, sm_trig = 1'b0;
  logic [1:0]  sm_mode = '0;
  logic [11:0] sm_cp = '0;
  logic [31:0] sm_data;
  logic        sm_xhs, sm_busy, sm_act, sm_done;
  logic [10:0] sm_ln;

  img_sensor_emu u_df (
    .dck(dck), .rst(df_rst), .frame_trig(df_trig), .mode(df_mode), .const_pix(df_cp),
    .data_par(df_data), .xhs(df_xhs), .busy(df_busy), .line_active(df_act),
    .line_num(df_ln), .frame_done(df_done)
  );

  img_sensor_emu #(.CH_PIX(SM_CH), .LINES(SM_LN)) u_sm (
    .dck(dck), .rst(sm_rst), .frame_trig(sm_trig), .mode(sm_mode), .const_pix(sm_cp),
    .data_par(sm_data), .xhs(sm_xhs), .busy(sm_busy), .line_active(sm_act),
    .line_num(sm_ln), .frame_done(sm_done)
  );

  rec_t q_df[$];
  rec_t q_sm[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] deinterleave(input logic [31:0] dp);
    logic [31:0] r;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++)
        r[8*k+i] = dp[4*i+k];
    return r;
  endfunction

  function automatic rec_t mk(input logic [31:0] lanes, input logic x, input logic b,
                              input logic a, input logic d, input int ln);
    rec_t r;
    r.lanes = lanes; r.xhs = x; r.busy = b; r.act = a; r.done = d; r.ln = 11'(ln);
    return r;
  endfunction

  // Pattern definition straight from the pixel rules.
  function automatic int pix_model(int k, int x, int y, int md, int cp, int ch);
    case (md)
      0:       return (k * ch + x) % 4096;
      1:       return y;
      2:       return ((((x / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 4095 : 0;
      default: return cp;
    endcase
  endfunction

  function automatic int sav_model(int i);
    case (i)
      0: return 'hFF;
      1: return 'hF0;
      4: return 'h08;
      default: return 0;
    endcase
  endfunction

  task automatic push(input int which, input rec_t r);
    if (which == 0) q_df.push_back(r);
    else            q_sm.push_back(r);
  endtask

  // Expected per-cycle output for the first nl lines of a frame (plus the
  // frame_done cycle when the whole frame is generated).
  task automatic gen_frame(input int which, input int ch, input int lines, input int nl,
                           input int md, input int cp);
    logic [31:0] idle_l, lw;
    int p0, p1, b;
    idle_l = {4{8'hA5}};
    for (int y = 0; y < nl; y++) begin
      for (int c = 0; c < XW; c++)    push(which, mk(idle_l, 0, 1, 0, 0, y));
      for (int c = 0; c < TL; c++)    push(which, mk(idle_l, 1, 1, 0, 0, y));
      for (int c = 0; c < 6; c++)     push(which, mk({4{8'(sav_model(c))}}, 1, 1, 0, 0, y));
      for (int j = 0; j < ch / 2; j++) begin
        for (int ph = 0; ph < 3; ph++) begin
          for (int k = 0; k < 4; k++) begin
            p0 = pix_model(k, 2 * j, y, md, cp, ch);
            p1 = pix_model(k, 2 * j + 1, y, md, cp, ch);
            if (ph == 0)      b = p0 / 16;
            else if (ph == 1) b = (p0 % 16) * 16 + p1 / 256;
            else              b = p1 % 256;
            lw[8*k +: 8] = 8'(b);
          end
          push(which, mk(lw, 1, 1, 1, 0, y));
        end
      end
      for (int c = 0; c < TAILL; c++) push(which, mk(idle_l, 1, 1, 0, 0, y));
    end
    if (nl == lines) push(which, mk(idle_l, 1, 0, 0, 1, lines - 1));
  endtask

  // Monitors: one pop-and-compare per presented cycle.
  always @(negedge dck) begin
    if (df_busy === 1'b1 || df_done === 1'b1) begin
      check("df_output_expected", 64'(q_df.size() != 0), 64'd1);
      if (q_df.size() != 0)
        check("df_cycle", 64'(mk(deinterleave(df_data), df_xhs, df_busy, df_act, df_done, int'(df_ln))),
              64'(q_df.pop_front()));
    end
  end

  always @(negedge dck) begin
    if (sm_busy === 1'b1 || sm_done === 1'b1) begin
      check("sm_output_expected", 64'(q_sm.size() != 0), 64'd1);
      if (q_sm.size() != 0)
        check("sm_cycle", 64'(mk(deinterleave(sm_data), sm_xhs, sm_busy, sm_act, sm_done, int'(sm_ln))),
              64'(q_sm.pop_front()));
    end
  end

  task automatic check_idle_sm(input string tag);
    check({tag, "_lanes"}, 64'(deinterleave(sm_data)), 64'({4{8'hA5}}));
    check({tag, "_xhs"},   64'(sm_xhs),  64'd1);
    check({tag, "_busy"},  64'(sm_busy), 64'd0);
    check({tag, "_act"},   64'(sm_act),  64'd0);
    check({tag, "_line"},  64'(sm_ln),   64'd0);
    check({tag, "_done"},  64'(sm_done), 64'd0);
  endtask

  // Trigger one small-instance frame; inputs are scrambled afterwards so a
  // missing latch shows up in the pixel data.
  task automatic trig_sm(input int md, input int cp);
    @(posedge dck); #1;
    sm_trig = 1'b1; sm_mode = 2'(md); sm_cp = 12'(cp);
    gen_frame(1, SM_CH, SM_LN, SM_LN, md, cp);
    @(posedge dck); #1;
    sm_trig = 1'b0; sm_mode = 2'($urandom); sm_cp = 12'($urandom);
  endtask

  task automatic drain_sm(input string tag);
    int n = 0;
    while (q_sm.size() != 0 && n < SM_FRAME + 100) begin
      @(posedge dck); n++;
    end
    check({tag, "_drained"}, 64'(q_sm.size()), 64'd0);
  endtask

  initial begin
    int md;
    // Reset state of both instances
    repeat (3) @(posedge dck);
    #1;
    df_rst = 1'b0; sm_rst = 1'b0;
    check_idle_sm("reset_sm");
    check("reset_df_lanes", 64'(deinterleave(df_data)), 64'({4{8'hA5}}));
    check("reset_df_xhs",   64'(df_xhs),  64'd1);
    check("reset_df_busy",  64'(df_busy), 64'd0);

    // Default geometry, mode 0: first three lines, then reset mid-PIX.
    @(posedge dck); #1;
    df_trig = 1'b1; df_mode = 2'd0;
    gen_frame(0, DF_CH, DF_LN, 3, 0, 0);
    @(posedge dck); #1;
    df_trig = 1'b0; df_mode = 2'd3;
    repeat (2 * 830 + XW + TL + 6 + 100) @(posedge dck);
    #1;
    check("df_pix_active", 64'(df_act), 64'd1);
    df_rst = 1'b1;
    @(posedge dck); #1;
    q_df.delete();
    df_rst = 1'b0;
    check("df_rst_lanes", 64'(deinterleave(df_data)), 64'({4{8'hA5}}));
    check("df_rst_busy",  64'(df_busy), 64'd0);
    check("df_rst_xhs",   64'(df_xhs),  64'd1);
    check("df_rst_line",  64'(df_ln),   64'd0);

    // Every pattern once on the small geometry
    trig_sm(0, 0);                drain_sm("mode0");
    trig_sm(1, 0);                drain_sm("mode1");
    trig_sm(2, 0);                drain_sm("mode2");

    // Mode 3 with triggers during line-0 PIX and on the frame_done cycle
    trig_sm(3, 'hABC);
    repeat (34) @(posedge dck);
    #1 sm_trig = 1'b1;
    @(posedge dck); #1 sm_trig = 1'b0;
    begin
      int n = 0;
      while (q_sm.size() > 1 && n < SM_FRAME + 100) begin
        @(posedge dck); n++;
      end
    end
    #1 sm_trig = 1'b1;
    @(posedge dck); #1 sm_trig = 1'b0;
    check("glitch_done_seen", 64'(q_sm.size()), 64'd0);
    repeat (5) @(posedge dck);
    #1;
    check("no_retrigger_busy", 64'(sm_busy), 64'd0);
    check("no_retrigger_done", 64'(sm_done), 64'd0);

    // Reset during line 1 PIX, then a complete frame
    md = int'($urandom_range(0, 3));
    trig_sm(md, int'($urandom));
    repeat (110 + XW + TL + 6 + 10) @(posedge dck);
    #1 sm_rst = 1'b1;
    @(posedge dck); #1;
    q_sm.delete();
    sm_rst = 1'b0;
    check_idle_sm("midrst_sm");
    trig_sm(int'($urandom_range(0, 3)), int'($urandom));
    drain_sm("after_rst");

    // Random frames
    for (int f = 0; f < 2; f++) begin
      trig_sm(int'($urandom_range(0, 3)), int'($urandom));
      drain_sm("random");
    end

    repeat (4) @(posedge dck);
    #1;
    check("final_sm_queue", 64'(q_sm.size()), 64'd0);
    check("final_sm_busy",  64'(sm_busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1);
  end

endmodule
